// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the digit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;

  // One extra bit so the counter can represent W/2 itself without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w / 2) + 1;
  endfunction

endpackage

// File: rtl/add_slice2.sv
// Combinational 2-bit adder slice built from two chained full-adder stages.
module add_slice2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       ci,
  output logic [1:0] o,
  output logic       co
);

  logic c0_s;

  // Two ripple full-adder stages
  always_comb begin
    o[0] = x[0] ^ y[0] ^ ci;
    c0_s = (x[0] & y[0]) | (ci & (x[0] ^ y[0]));
    o[1] = x[1] ^ y[1] ^ c0_s;
    co   = (x[1] & y[1]) | (c0_s & (x[1] ^ y[1]));
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial W-bit adder: one 2-bit slice reused LSB-first, done pulse on completion.
// Optional subtract mode (sub port) enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W / 2 - 1);

  state_t             state_r;
  state_t             next_s;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [W-1:0]       acc_r;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               busy_r;
  logic               done_r;

  logic               sub_s;
  logic               last_s;
  logic [DIGIT_W-1:0] slice_o_s;
  logic               slice_co_s;
  logic [W-1:0]       acc_next_s;
  logic [W-1:0]       b_load_s;
  logic               carry_load_s;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  add_slice2 u_slice (
    .x  (a_r[DIGIT_W-1:0]),
    .y  (b_r[DIGIT_W-1:0]),
    .ci (carry_r),
    .o  (slice_o_s),
    .co (slice_co_s)
  );

  // Operand/carry load values and the shifted result for this digit
  always_comb begin
    last_s     = (cnt_r == LAST_CNT);
    acc_next_s = acc_r >> DIGIT_W;
    acc_next_s[W-1 -: DIGIT_W] = slice_o_s;
    if (sub_s) begin
      // Two's-complement subtract: a + ~b + 1
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_s = ST_RUN;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_RUN;
        end
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s == ST_RUN);
      done_r  <= (next_s == ST_DONE);
    end
  end

  // Datapath: operand latch, digit shifting, result capture
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b_load_s;
            carry_r <= carry_load_s;
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {W{1'b0}};
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          a_r     <= a_r >> DIGIT_W;
          b_r     <= b_r >> DIGIT_W;
          carry_r <= slice_co_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          // Published outputs move only when the final digit lands
          if (last_s) begin
            sum_r  <= acc_next_s;
            cout_r <= slice_co_s;
          end
        end
        ST_DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven self-checking bench for serial_add_ctrl (W=8).
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_b;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_sum;
  logic         last_cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  serial_add_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full operation: accept, W/2 run cycles, done pulse, back to idle.
  task automatic do_op(input vec_t v, input string tag);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy@accept"}, 32'(busy), 32'd1);
    for (int i = 1; i <= W / 2; i++) begin
      @(posedge clk); #1;
      if (i < W / 2) begin
        check({tag, " run busy"}, 32'(busy), 32'd1);
        check({tag, " run done"}, 32'(done), 32'd0);
        check({tag, " run sum hold"}, 32'(sum), 32'(last_sum));
        check({tag, " run cout hold"}, 32'(cout), 32'(last_cout));
      end else begin
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(v.exp_sum));
        check({tag, " cout"}, 32'(cout), 32'(v.exp_cout));
      end
    end
    @(posedge clk); #1;
    check({tag, " done cleared"}, 32'(done), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    last_sum  = v.exp_sum;
    last_cout = v.exp_cout;
  endtask

  initial begin
    vec_t v;
    bit saw_done;
    start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rst_b = 1'b0;
    last_sum = '0; last_cout = 1'b0;

    vecs.push_back('{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("post-rst idle busy", 32'(busy), 32'd0);

    foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i));

    // start held high; operands changed during RUN; no queued request
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("hold busy@0", 32'(busy), 32'd1);
    a = 8'h11; b = 8'h22;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      if (e == 4) begin
        check("hold done@4", 32'(done), 32'd1);
        check("hold sum", 32'(sum), 32'h8D);
        check("hold cout", 32'(cout), 32'd0);
      end else if (e == 5) begin
        check("hold idle busy@5", 32'(busy), 32'd0);
        check("hold idle done@5", 32'(done), 32'd0);
      end else if (e == 6) begin
        check("hold reaccept busy@6", 32'(busy), 32'd1);
      end else begin
        check("hold run busy", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    for (int e = 7; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 10) begin
        check("second done@10", 32'(done), 32'd1);
        check("second sum", 32'(sum), 32'h33);
        check("second cout", 32'(cout), 32'd0);
      end else begin
        check("second run sum hold", 32'(sum), 32'h8D);
      end
    end
    @(posedge clk); #1;
    last_sum = 8'h33; last_cout = 1'b0;

    // Reset during the second RUN cycle discards the operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst sum", 32'(sum), 32'd0);
    check("midrst cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    saw_done = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no activity after midrst", 32'(saw_done), 32'd0);
    last_sum = '0; last_cout = 1'b0;
    v = '{8'hC3, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1};
    do_op(v, "after-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer that adds two W-bit operands over several cycles by reusing a single 2-bit adder slice, one 2-bit digit per clock, least significant digit first. It latches the operands on a start request, drives the slice with the current digit and the registered inter-digit carry, and assembles the result in a shift register. It reports completion with a one-cycle done pulse. It is the area-lean alternative to a full-width ripple adder in the lab datapath.

## Interface
- W, default 8: operand width in bits; must be even and ≥ 2.
- clk  in  1  rising-edge clock.
- rst_b  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  W  first operand; sampled with start.
- b  in  W  second operand; sampled with start.
- cin  in  1  carry-in; sampled with start.
- sub  in  1  subtract select; present only with SERIAL_ADD_SUB_EN.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  W  result; holds the last completed value.
- cout  out  1  final carry; holds the last completed value.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: latch a, b and the carry (cin), clear the digit counter, then go to RUN. IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - Feed operand bits [1:0] and the carry register to the slice.
  - Shift the slice sum into the top of the result shift register.
  - Shift the operands right by 2 and register the slice carry-out.
  - Increment the counter.
- After W/2 digits, go to DONE. On that transition, copy the shift register to sum and the final carry to cout.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE and is not queued. Operand changes after acceptance have no effect.
- sum and cout change only on the transition into DONE. During RUN they keep the previous result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1); unsigned.
- Reset, including mid-operation, immediately forces:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0
  - all internal registers cleared
  
  A partial computation is discarded and produces no done pulse after rst_b is released.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0.
- Start accepted at edge 0: busy=1 after edge 0.
- Digits are processed at edges 1..W/2. At edge W/2 the state becomes DONE, busy=0, done=1, and sum/cout are updated.
- At edge W/2+1 the state becomes IDLE and done=0.
- Latency from the accepting edge to done high: W/2 cycles (4 for W=8).
- Earliest next acceptance: edge W/2+2.
- Throughput: one operation per W/2+2 cycles.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists and is latched with start.
  - sub=1: the latched b is bitwise inverted and the initial carry is forced to 1; cin is ignored. The result is a − b mod 2^W, and cout=1 means no borrow (a ≥ b).
  - sub=0: plain add as specified above.
- Undefined: no sub port, add only. Behaviour is identical to the sub=0 case.

## Structure
- Package serial_add_pkg:
  - State typedef (ST_IDLE, ST_RUN, ST_DONE).
  - DIGIT_W = 2.
  - Counter width function clog2(W/2)+1.
- Sub-module add_slice2: combinational 2-bit adder built from two full-adder stages. Inputs x[1:0], y[1:0], ci; outputs o[1:0], co. The controller instantiates exactly one.

## Test plan
- Reset: hold rst_b=0 → busy=0, done=0, sum=0, cout=0; FSM in IDLE after release.
- W=8, a=0x5A, b=0x33, cin=0, start pulse → done high exactly 4 cycles after acceptance with sum=0x8D, cout=0; busy high for 4 cycles.
- Boundary cases, W=8:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
  - a=0, b=0, cin=0 → sum=0, cout=0.
- Start held high throughout, with operands changed to 0x11/0x22 during RUN → the first result is unchanged. The next acceptance occurs only from IDLE, 6 cycles after the first, and yields 0x33.
- rst_b pulsed low during the 2nd RUN cycle → all outputs 0 immediately; no done pulse afterward; a new start completes normally.
- With SERIAL_ADD_SUB_EN:
  - a=0x10, b=0x01, sub=1 → sum=0x0F, cout=1.
  - a=0x01, b=0x02, sub=1 → sum=0xFF, cout=0.
  - sub=0 matches the add case.
